// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view; master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch (IF) vs memory stage (DM, priority), fixed-latency response routing.
// Optional fetch anti-starvation guard: define ARB_FETCH_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_port_arbiter_if.slave bus
);
    logic w_force_if;
    logic w_dm_win;
    logic w_if_win;
    logic w_issue;
    logic w_resp;

    // Stage k holds the access issued k cycles ago.
    logic [MEM_LAT:1] r_vld;
    logic [MEM_LAT:1] r_own_dm;
    logic [MEM_LAT:1] r_rd;

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1) begin : g_param_chk
        $error("mem_port_arbiter: MEM_LAT must be 1..4 and STARVE_LIMIT >= 1");
    end

`ifdef ARB_FETCH_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve;

    assign w_force_if = bus.if_req && bus.dm_req && (r_starve == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge i_clk) begin
        if (i_rst || !bus.if_req || w_if_win) r_starve <= '0;
        else if (w_dm_win)                    r_starve <= r_starve + 1'b1;
    end

    assign bus.stall_mem = !i_rst && bus.dm_req && !w_dm_win;
`else
    assign w_force_if    = 1'b0;
    assign bus.stall_mem = 1'b0;
`endif

    assign w_dm_win = !i_rst && bus.dm_req && !w_force_if;
    assign w_if_win = !i_rst && bus.if_req && !w_dm_win;
    assign w_issue  = w_dm_win || w_if_win;

    assign bus.dm_gnt    = w_dm_win;
    assign bus.if_gnt    = w_if_win;
    assign bus.stall_if  = !i_rst && bus.if_req && !w_if_win;

    assign bus.mem_en    = w_issue;
    assign bus.mem_we    = w_dm_win && bus.dm_we;
    assign bus.mem_addr  = w_dm_win ? bus.dm_addr : (w_if_win ? bus.if_addr : '0);
    assign bus.mem_wdata = w_dm_win ? bus.dm_wdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld    <= '0;
            r_own_dm <= '0;
            r_rd     <= '0;
        end else begin
            r_vld[1]    <= w_issue;
            r_own_dm[1] <= w_dm_win;
            r_rd[1]     <= w_if_win || (w_dm_win && !bus.dm_we);
            for (int k = 2; k <= MEM_LAT; k++) begin
                r_vld[k]    <= r_vld[k-1];
                r_own_dm[k] <= r_own_dm[k-1];
                r_rd[k]     <= r_rd[k-1];
            end
        end
    end

    // Responses are suppressed during reset so nothing issued before it can surface.
    assign w_resp = !i_rst && r_vld[MEM_LAT] && r_rd[MEM_LAT];

    assign bus.dm_rvalid = w_resp && r_own_dm[MEM_LAT];
    assign bus.if_rvalid = w_resp && !r_own_dm[MEM_LAT];
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
endmodule
